i2c_master: RTL and testbench

Byte-level I2C master controller that drives the on-chip `i2c_slave` bus (SCL + open-drain SDA) from a simple command/handshake interface. It generates START, repeated START, STOP, 8-bit write with ACK check, and 8-bit read with ACK/NACK. It sits directly upstream of `i2c_slave` and also serves as the bench master for slave verification.

---
 rtl/i2c_master.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: byte-level I2C master with a command/handshake front end.
//
// Generates START, repeated START, STOP, 8-bit WRITE with ACK check and
// 8-bit READ with ACK/NACK. Each SCL period is four quarters of QTR
// sys_clk cycles.
//
// Parameters:
//   QTR        sys_clk cycles per SCL quarter period (>= 1)
// Ports:
//   sys_clk    clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd_valid  command request
//   cmd[2:0]   0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5-7 no-op
//   wr_data    byte for WRITE, sampled at acceptance
//   cmd_ready  command can be accepted (IDLE or HOLD)
//   done       one-cycle pulse when a command completes
//   rd_data    last byte read (MSB first on the wire)
//   ack_err    slave NACKed the last WRITE
//   busy       bus owned (START accepted until STOP completes)
//   scl        push-pull SCL
//   sda        open-drain SDA (driven 0 or released)
//
// Optional feature macro: I2C_NACK_AUTOSTOP_EN
//   When defined, a NACKed WRITE runs a STOP immediately and ends in IDLE,
//   with a single done pulse after the STOP.

module i2c_master #(
    parameter int unsigned QTR = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    input  logic [7:0] wr_data,
    output logic       cmd_ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       busy,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned    DW       = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(QTR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_START,
        S_STOP,
        S_WRITE,
        S_READ
    } state_e;

    typedef enum logic [2:0] {
        CMD_START     = 3'd0,
        CMD_STOP      = 3'd1,
        CMD_WRITE     = 3'd2,
        CMD_READ_ACK  = 3'd3,
        CMD_READ_NACK = 3'd4
    } cmd_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          rd_ack_q, rd_ack_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          sda_in;
    logic          legal;
    logic          enter;
    logic          finish;
    logic          in_hold;
    cmd_e          cmd_c;

    assign sda    = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in = sda;
    assign cmd_c  = cmd_e'(cmd);

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign ack_err   = ack_err_q;
    assign busy      = busy_q;
    assign scl       = scl_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        rd_ack_d    = rd_ack_q;
        scl_d       = scl_q;
        sda_oe_d    = sda_oe_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ack_err_d   = ack_err_q;
        rd_data_d   = rd_data_q;
        legal       = 1'b0;
        enter       = 1'b0;
        finish      = 1'b0;
        in_hold     = (state_q == S_HOLD);

        if (state_q == S_IDLE || state_q == S_HOLD) begin
            if (cmd_valid && cmd_ready_q) begin
                legal = 1'b1;
                case (cmd_c)
                    CMD_START: begin
                        state_d = S_START;
                        busy_d  = 1'b1;
                    end
                    CMD_STOP: begin
                        if (in_hold) state_d = S_STOP;
                        else         legal   = 1'b0;
                    end
                    CMD_WRITE: begin
                        if (in_hold) begin
                            state_d   = S_WRITE;
                            sh_d      = wr_data;
                            ack_err_d = 1'b0;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    CMD_READ_ACK, CMD_READ_NACK: begin
                        if (in_hold) begin
                            state_d  = S_READ;
                            rd_ack_d = (cmd_c == CMD_READ_ACK);
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    enter       = 1'b1;
                    cmd_ready_d = 1'b0;
                    div_d       = '0;
                    qtr_d       = 2'd0;
                    bit_d       = 4'd0;
                end else begin
                    // Illegal commands complete at once with no bus activity.
                    done_d = 1'b1;
                end
            end
        end else if (div_q != DIV_LAST) begin
            div_d = div_q + DW'(1);
        end else begin
            div_d = '0;
            // Last cycle of q2 is the sample point for SDA.
            if (qtr_q == 2'd2) begin
                if (state_q == S_WRITE && bit_q == 4'd8) ack_err_d = sda_in;
                if (state_q == S_READ && bit_q != 4'd8)  sh_d = {sh_q[6:0], sda_in};
            end
            if (qtr_q != 2'd3) begin
                qtr_d = qtr_q + 2'd1;
                enter = 1'b1;
            end else if ((state_q == S_WRITE || state_q == S_READ) && bit_q != 4'd8) begin
                bit_d = bit_q + 4'd1;
                qtr_d = 2'd0;
                enter = 1'b1;
            end else begin
                finish = 1'b1;
            end
        end

        if (finish) begin
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
            case (state_q)
                S_START: state_d = S_HOLD;
                S_STOP: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                S_READ: begin
                    state_d   = S_HOLD;
                    scl_d     = 1'b0;
                    rd_data_d = sh_q;
                end
                default: begin
                    state_d = S_HOLD;
                    scl_d   = 1'b0;
                end
            endcase
`ifdef I2C_NACK_AUTOSTOP_EN
            // A NACKed byte chains straight into STOP; done is deferred to its end.
            if (state_q == S_WRITE && ack_err_q) begin
                state_d     = S_STOP;
                qtr_d       = 2'd0;
                enter       = 1'b1;
                done_d      = 1'b0;
                cmd_ready_d = 1'b0;
            end
`endif
        end

        // Wire actions happen on the first cycle of the quarter being entered.
        if (enter) begin
            case (state_d)
                S_START: begin
                    case (qtr_d)
                        2'd0:    sda_oe_d = 1'b0;
                        2'd1:    scl_d    = 1'b1;
                        2'd2:    sda_oe_d = 1'b1;
                        default: scl_d    = 1'b0;
                    endcase
                end
                S_STOP: begin
                    case (qtr_d)
                        2'd0: begin
                            sda_oe_d = 1'b1;
                            scl_d    = 1'b0;
                        end
                        2'd1:    scl_d    = 1'b1;
                        2'd2:    sda_oe_d = 1'b0;
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (qtr_d == 2'd0) begin
                        scl_d = 1'b0;
                        if (bit_d == 4'd8) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~sh_d[7];
                            sh_d     = {sh_d[6:0], 1'b0};
                        end
                    end else if (qtr_d == 2'd2) begin
                        scl_d = 1'b1;
                    end
                end
                S_READ: begin
                    if (qtr_d == 2'd0) begin
                        scl_d    = 1'b0;
                        sda_oe_d = (bit_d == 4'd8) && rd_ack_d;
                    end else if (qtr_d == 2'd2) begin
                        scl_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            sh_q        <= '0;
            rd_ack_q    <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            rd_ack_q    <= rd_ack_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ack_err_q   <= ack_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed self-checking bench for i2c_master (QTR = 2).
// A small behavioural slave on the bus ACKs writes, serves read bytes,
// captures written bits on SCL rising edges and watches for START/STOP.

module tb_i2c_master;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd = 3'd7;
    logic [7:0] wr_data = 8'h00;
    wire        cmd_ready;
    wire        done;
    wire  [7:0] rd_data;
    wire        ack_err;
    wire        busy;
    wire        scl;
    wire        sda;

    pullup (sda);

    i2c_master #(.QTR(2)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .wr_data   (wr_data),
        .cmd_ready (cmd_ready),
        .done      (done),
        .rd_data   (rd_data),
        .ack_err   (ack_err),
        .busy      (busy),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 sys_clk = ~sys_clk;

    localparam int MODE_NONE = 0;
    localparam int MODE_ACK  = 1;
    localparam int MODE_READ = 2;

    int         neg_count = 0;
    int         base = 0;
    int         mode = MODE_NONE;
    int         sbit;
    logic [7:0] slv_rd = 8'h00;
    logic       slave_oe;
    logic [7:0] wr_cap = 8'h00;
    logic       mack_bit = 1'b0;
    int         start_seen = 0;
    int         stop_seen = 0;
    int         passed = 0;
    int         total = 0;

    always @(negedge scl) neg_count++;

    always_comb begin
        sbit     = neg_count - base;
        slave_oe = 1'b0;
        if (mode == MODE_ACK)       slave_oe = (sbit == 8);
        else if (mode == MODE_READ) slave_oe = (sbit >= 0) && (sbit < 8) && !slv_rd[7 - (sbit & 7)];
    end

    assign sda = slave_oe ? 1'b0 : 1'bz;

    always @(posedge scl) begin
        if (sbit >= 0 && sbit < 8) wr_cap = {wr_cap[6:0], sda};
        else if (sbit == 8)        mack_bit = sda;
    end

    always @(negedge sda) if (scl === 1'b1) start_seen++;
    always @(posedge sda) if (scl === 1'b1) stop_seen++;

    task automatic slave_set(input int m, input logic [7:0] rd);
        mode   = m;
        slv_rd = rd;
        base   = neg_count;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd       = c;
        wr_data   = d;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        cmd       = 3'd7;
        wr_data   = 8'h00;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge sys_clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        total++; if (scl !== 1'b1)       $display("FAIL rst_scl: got %b want 1", scl); else passed++;
        total++; if (sda !== 1'b1)       $display("FAIL rst_sda: got %b want 1", sda); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0)      $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (rd_data !== 8'h00)  $display("FAIL rst_rd_data: got %h want 00", rd_data); else passed++;
        total++; if (ack_err !== 1'b0)   $display("FAIL rst_ack_err: got %b want 0", ack_err); else passed++;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_illegal();
        int n;
        issue(3'd2, 8'h12);
        wait_done(n);
        total++; if (n !== 0)       $display("FAIL ill_wr_done_lat: got %0d want 0", n); else passed++;
        total++; if (scl !== 1'b1)  $display("FAIL ill_wr_scl: got %b want 1", scl); else passed++;
        total++; if (sda !== 1'b1)  $display("FAIL ill_wr_sda: got %b want 1", sda); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ill_wr_busy: got %b want 0", busy); else passed++;
        @(posedge sys_clk); #1;
        total++; if (done !== 1'b0) $display("FAIL ill_done_width: got %b want 0", done); else passed++;
        issue(3'd6, 8'h00);
        total++; if (done !== 1'b1) $display("FAIL ill_code6_done: got %b want 1", done); else passed++;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_start_write();
        int n;
        int s0;
        s0 = start_seen;
        slave_set(MODE_NONE, 8'h00);
        issue(3'd0, 8'h00);
        total++; if (busy !== 1'b1) $display("FAIL start_busy_rise: got %b want 1", busy); else passed++;
        wait_done(n);
        total++; if (n !== 8)                $display("FAIL start_len: got %0d want 8", n); else passed++;
        total++; if (start_seen - s0 !== 1)  $display("FAIL start_cond: got %0d want 1", start_seen - s0); else passed++;
        total++; if (scl !== 1'b0)           $display("FAIL start_scl: got %b want 0", scl); else passed++;
        total++; if (sda !== 1'b0)           $display("FAIL start_sda: got %b want 0", sda); else passed++;
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'hF4);
        wait_done(n);
        total++; if (n !== 72)         $display("FAIL wr_f4_len: got %0d want 72", n); else passed++;
        total++; if (wr_cap !== 8'hF4) $display("FAIL wr_f4_bits: got %h want f4", wr_cap); else passed++;
        total++; if (ack_err !== 1'b0) $display("FAIL wr_f4_ack: got %b want 0", ack_err); else passed++;
        total++; if (busy !== 1'b1)    $display("FAIL wr_f4_busy: got %b want 1", busy); else passed++;
        @(posedge sys_clk); #1;
        total++; if (done !== 1'b0)    $display("FAIL wr_f4_done_width: got %b want 0", done); else passed++;
        total++; if (scl !== 1'b0)     $display("FAIL wr_f4_hold_scl: got %b want 0", scl); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'hC1);
        wait_done(n);
        total++; if (n !== 72)           $display("FAIL b2b_c1_len: got %0d want 72", n); else passed++;
        total++; if (wr_cap !== 8'hC1)   $display("FAIL b2b_c1_bits: got %h want c1", wr_cap); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", cmd_ready); else passed++;
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'hC2);
        wait_done(n);
        total++; if (n !== 72)           $display("FAIL b2b_c2_len: got %0d want 72", n); else passed++;
        total++; if (wr_cap !== 8'hC2)   $display("FAIL b2b_c2_bits: got %h want c2", wr_cap); else passed++;
    endtask

    task automatic test_read();
        int n;
        int s0;
        int p0;
        s0 = start_seen;
        slave_set(MODE_NONE, 8'h00);
        issue(3'd0, 8'h00);
        wait_done(n);
        total++; if (n !== 8)               $display("FAIL rs_len: got %0d want 8", n); else passed++;
        total++; if (start_seen - s0 !== 1) $display("FAIL rs_cond: got %0d want 1", start_seen - s0); else passed++;
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'hF5);
        wait_done(n);
        total++; if (wr_cap !== 8'hF5)  $display("FAIL wr_f5_bits: got %h want f5", wr_cap); else passed++;
        total++; if (ack_err !== 1'b0)  $display("FAIL wr_f5_ack: got %b want 0", ack_err); else passed++;
        slave_set(MODE_READ, 8'h91);
        issue(3'd3, 8'h00);
        wait_done(n);
        total++; if (n !== 72)          $display("FAIL rd_ack_len: got %0d want 72", n); else passed++;
        total++; if (rd_data !== 8'h91) $display("FAIL rd_ack_data: got %h want 91", rd_data); else passed++;
        total++; if (mack_bit !== 1'b0) $display("FAIL rd_ack_bit9: got %b want 0", mack_bit); else passed++;
        slave_set(MODE_READ, 8'h92);
        issue(3'd4, 8'h00);
        wait_done(n);
        total++; if (rd_data !== 8'h92) $display("FAIL rd_nack_data: got %h want 92", rd_data); else passed++;
        total++; if (mack_bit !== 1'b1) $display("FAIL rd_nack_bit9: got %b want 1", mack_bit); else passed++;
        p0 = stop_seen;
        slave_set(MODE_NONE, 8'h00);
        issue(3'd1, 8'h00);
        wait_done(n);
        total++; if (n !== 8)              $display("FAIL stop_len: got %0d want 8", n); else passed++;
        total++; if (stop_seen - p0 !== 1) $display("FAIL stop_cond: got %0d want 1", stop_seen - p0); else passed++;
        total++; if (busy !== 1'b0)        $display("FAIL stop_busy: got %b want 0", busy); else passed++;
        total++; if (scl !== 1'b1)         $display("FAIL stop_scl: got %b want 1", scl); else passed++;
        total++; if (sda !== 1'b1)         $display("FAIL stop_sda: got %b want 1", sda); else passed++;
    endtask

    task automatic test_nack();
        int n;
        int p0;
        slave_set(MODE_NONE, 8'h00);
        issue(3'd0, 8'h00);
        wait_done(n);
        p0 = stop_seen;
        issue(3'd2, 8'hA0);
        wait_done(n);
        total++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err: got %b want 1", ack_err); else passed++;
`ifdef I2C_NACK_AUTOSTOP_EN
        total++; if (n !== 80)             $display("FAIL nack_len: got %0d want 80", n); else passed++;
        total++; if (stop_seen - p0 !== 1) $display("FAIL nack_stop: got %0d want 1", stop_seen - p0); else passed++;
        total++; if (busy !== 1'b0)        $display("FAIL nack_busy: got %b want 0", busy); else passed++;
        total++; if (scl !== 1'b1)         $display("FAIL nack_scl: got %b want 1", scl); else passed++;
`else
        total++; if (n !== 72)             $display("FAIL nack_len: got %0d want 72", n); else passed++;
        total++; if (stop_seen - p0 !== 0) $display("FAIL nack_stop: got %0d want 0", stop_seen - p0); else passed++;
        total++; if (busy !== 1'b1)        $display("FAIL nack_busy: got %b want 1", busy); else passed++;
        total++; if (scl !== 1'b0)         $display("FAIL nack_scl: got %b want 0", scl); else passed++;
        issue(3'd1, 8'h00);
        wait_done(n);
        total++; if (busy !== 1'b0)        $display("FAIL nack_stop_busy: got %b want 0", busy); else passed++;
`endif
    endtask

    task automatic test_ignore_reset();
        int n;
        issue(3'd0, 8'h00);
        wait_done(n);
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'h55);
        total++; if (ack_err !== 1'b0)   $display("FAIL ign_ack_clear: got %b want 0", ack_err); else passed++;
        repeat (20) @(posedge sys_clk);
        #1;
        total++; if (cmd_ready !== 1'b0) $display("FAIL ign_ready: got %b want 0", cmd_ready); else passed++;
        cmd_valid = 1'b1;
        cmd       = 3'd1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        cmd       = 3'd7;
        wait_done(n);
        total++; if (n !== 51)         $display("FAIL ign_len: got %0d want 51", n); else passed++;
        total++; if (wr_cap !== 8'h55) $display("FAIL ign_bits: got %h want 55", wr_cap); else passed++;
        total++; if (scl !== 1'b0)     $display("FAIL ign_scl: got %b want 0", scl); else passed++;
        total++; if (busy !== 1'b1)    $display("FAIL ign_busy: got %b want 1", busy); else passed++;
        slave_set(MODE_ACK, 8'h00);
        issue(3'd2, 8'h3C);
        repeat (30) @(posedge sys_clk);
        #1;
        rst_n = 1'b0;
        @(posedge sys_clk); #1;
        total++; if (scl !== 1'b1)       $display("FAIL mrst_scl: got %b want 1", scl); else passed++;
        total++; if (sda !== 1'b1)       $display("FAIL mrst_sda: got %b want 1", sda); else passed++;
        total++; if (busy !== 1'b0)      $display("FAIL mrst_busy: got %b want 0", busy); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL mrst_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (done !== 1'b0)      $display("FAIL mrst_done: got %b want 0", done); else passed++;
        total++; if (rd_data !== 8'h00)  $display("FAIL mrst_rd_data: got %h want 00", rd_data); else passed++;
        rst_n = 1'b1;
        slave_set(MODE_NONE, 8'h00);
        @(posedge sys_clk); #1;
        issue(3'd0, 8'h00);
        wait_done(n);
        total++; if (n !== 8)       $display("FAIL post_rst_start: got %0d want 8", n); else passed++;
        issue(3'd1, 8'h00);
        wait_done(n);
        total++; if (n !== 8)       $display("FAIL post_rst_stop: got %0d want 8", n); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_illegal();
        test_start_write();
        test_back_to_back();
        test_read();
        test_nack();
        test_ignore_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
